local_predictor_table: RTL
==========================

// Module: local_predictor_table
// PURPOSE
//  Reader side of the global history state: uses local_src_i (2-bit global history) to pick one
//  of four banks of 2-bit saturating counters, indexed by low PC bits. Gives a taken/untaken
//  prediction for the fetch-stage PC. Trains the selected counter when a branch resolves in execute.
//  Sits in the branch-prediction unit beside the global history register.
// PARAMETERS
//  INDEX_BITS  5   counters per bank = 2**INDEX_BITS; index = pc[INDEX_BITS+1:2]
//  PC_WIDTH    32  width of the PC inputs
// PORTS
//  clk_i              in   1          clock; all state updates on posedge
//  reset_i            in   1          synchronous, active-high reset
//  local_src_i        in   2          bank select from global history (00 UU, 01 UT, 10 TU, 11 TT)
//  pc_f_i             in   PC_WIDTH   fetch-stage PC (lookup address)
//  pc_e_i             in   PC_WIDTH   execute-stage PC (training address)
//  stall_e_i          in   1          execute stall; blocks training
//  branch_op_e_i      in   2          bit0 = conditional branch in execute
//  pc_src_res_e_i     in   1          resolved outcome in execute (1 = taken)
//  pc_src_pred_e_i    in   1          prediction made for that branch, carried down the pipeline
//  pc_src_pred_f_o    out  1          prediction for pc_f_i (1 = taken)
//  mispredict_e_o     out  1          registered flag: last trained branch was mispredicted
// BEHAVIOUR
//  - Clock: one clock, clk_i. Reset: reset_i, synchronous and active-high.
//  - Reset: every counter in all 4 banks = WU (2'b01); mispredict_e_o = 0.
//    After reset, pc_src_pred_f_o = 0 for any PC and any bank.
//  - Counter encoding: SU=00, WU=01, WT=10, ST=11.
//    Prediction = counter[1].
//  - Lookup is combinational, zero latency:
//    pc_src_pred_f_o = bank[local_src_i][pc_f_i[INDEX_BITS+1:2]][1].
//  - Training condition: upd = branch_op_e_i[0] & ~stall_e_i.
//    The entry trained is bank[local_src_i][pc_e_i[INDEX_BITS+1:2]].
//    The write takes effect at the next posedge.
//  - Transitions on upd:
//    - taken: SU->WU, WU->WT, WT->ST, ST->ST (saturates).
//    - untaken: ST->WT, WT->WU, WU->SU, SU->SU (saturates).
//    - All other entries hold their value.
//  - Bank select for lookup and training is the same-cycle local_src_i.
//    The history register updates on the same edge as the counter.
//    Training therefore uses the pre-update history.
//  - Read/write collision: if a lookup and a training write hit the same bank and index in
//    the same cycle, the lookup returns the pre-write value. There is no bypass.
//  - mispredict_e_o: on every posedge, registers upd & (pc_src_pred_e_i != pc_src_res_e_i).
//    It is 0 in the cycle after any non-update cycle.
//  - Stall: if stall_e_i = 1, no counter changes and mispredict_e_o registers 0.
//    Lookup is unaffected by stall_e_i.
//  - branch_op_e_i[1] is ignored by this block.
//  - Reset mid-operation: reset_i wins over a same-cycle update.
//    The whole table returns to WU in one cycle.
//  - Index wrap: PCs that differ only above bit INDEX_BITS+1 alias to the same entry.
//    This aliasing is intended.
// STRUCTURE
//  - Shared package branch_pkg holds:
//    - the typedef sat_cnt_t: enum logic [1:0] {SU, WU, WT, ST}
//    - the constant SAT_CNT_RESET = WU
//    - the local_src encodings, shared with the history register
//  - Sub-module sat_counter2 is the per-entry next-state function (sat_cnt_t, taken -> next sat_cnt_t).
//    It is purely combinational and instantiated once on the training path.
//  - Table storage is a flop array [4][2**INDEX_BITS] of sat_cnt_t, written in one always_ff.
// TESTING
//  1. Reset, then sweep pc_f_i over 0x00..0x7C with all four local_src_i values.
//     -> pc_src_pred_f_o = 0 everywhere.
//  2. local_src_i=01, pc_e_i=0x40, 2 taken updates.
//     -> pc_f_i=0x40 with local_src_i=01 predicts 1.
//     -> the same PC with local_src_i=00, 10 or 11 still predicts 0.
//  3. Same entry, 5 taken updates, then 1 untaken.
//     -> still predicts 1 (ST->WT).
//     -> a 2nd untaken gives 0 (WU).
//  4. Hold stall_e_i=1 with branch_op_e_i=01 for 4 cycles.
//     -> no counter changes.
//     -> mispredict_e_o stays 0.
//  5. pc_src_pred_e_i=0, pc_src_res_e_i=1, upd=1.
//     -> mispredict_e_o=1 for exactly one cycle.
//  6. pc_f_i=pc_e_i=0x84 with INDEX_BITS=5 (aliases 0x04), same bank, same-cycle update.
//     -> the prediction shows the old value this cycle and the new value next cycle.
//     -> reset asserted during an update restores WU.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch-prediction types: 2-bit saturating counter encoding and the
// global-history bank encodings used by both the history register and the tables.
package branch_pkg;

    typedef enum logic [1:0] {
        SU = 2'b00,
        WU = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } sat_cnt_t;

    localparam sat_cnt_t SAT_CNT_RESET = WU;

    // Last two resolved outcomes, oldest first (U = untaken, T = taken).
    typedef enum logic [1:0] {
        LOCAL_SRC_UU = 2'b00,
        LOCAL_SRC_UT = 2'b01,
        LOCAL_SRC_TU = 2'b10,
        LOCAL_SRC_TT = 2'b11
    } local_src_t;

    function automatic logic sat_cnt_predict(input sat_cnt_t cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of one 2-bit saturating counter; purely combinational.
module sat_counter2
    import branch_pkg::*;
(
    input  sat_cnt_t cnt_i,
    input  logic     taken_i,
    output sat_cnt_t cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            unique case (cnt_i)
                SU:      cnt_o = WU;
                WU:      cnt_o = WT;
                WT:      cnt_o = ST;
                default: cnt_o = ST;
            endcase
        end else begin
            unique case (cnt_i)
                ST:      cnt_o = WT;
                WT:      cnt_o = WU;
                WU:      cnt_o = SU;
                default: cnt_o = SU;
            endcase
        end
    end

endmodule

// File: rtl/local_predictor_table.sv
// Four banks of 2-bit saturating counters selected by global history; combinational
// lookup for the fetch PC and single-entry training from the execute stage.
module local_predictor_table
    import branch_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int PC_WIDTH   = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [1:0]          local_src_i,
    input  logic [PC_WIDTH-1:0] pc_f_i,
    input  logic [PC_WIDTH-1:0] pc_e_i,
    input  logic                stall_e_i,
    input  logic [1:0]          branch_op_e_i,
    input  logic                pc_src_res_e_i,
    input  logic                pc_src_pred_e_i,
    output logic                pc_src_pred_f_o,
    output logic                mispredict_e_o
);

    localparam int NUM_BANKS = 4;
    localparam int ENTRIES   = 1 << INDEX_BITS;

    sat_cnt_t table_q [NUM_BANKS][ENTRIES];
    sat_cnt_t table_d [NUM_BANKS][ENTRIES];
    logic     mispredict_q;
    logic     mispredict_d;

    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [1:0]            bank;
    logic                  upd;
    sat_cnt_t              rd_cnt;
    sat_cnt_t              wr_cnt;
    sat_cnt_t              wr_cnt_next;

    // Bits outside the index window and branch_op[1] are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{pc_f_i[PC_WIDTH-1:INDEX_BITS+2], pc_f_i[1:0],
                           pc_e_i[PC_WIDTH-1:INDEX_BITS+2], pc_e_i[1:0],
                           branch_op_e_i[1]};

    assign bank   = local_src_i;
    assign rd_idx = pc_f_i[INDEX_BITS+1:2];
    assign wr_idx = pc_e_i[INDEX_BITS+1:2];
    assign upd    = branch_op_e_i[0] & ~stall_e_i;

    // Lookup reads the registered table, so a same-cycle write is not visible yet.
    assign rd_cnt          = table_q[bank][rd_idx];
    assign pc_src_pred_f_o = sat_cnt_predict(rd_cnt);

    assign wr_cnt = table_q[bank][wr_idx];

    sat_counter2 u_sat_counter2 (
        .cnt_i   (wr_cnt),
        .taken_i (pc_src_res_e_i),
        .cnt_o   (wr_cnt_next)
    );

    always_comb begin
        table_d = table_q;
        if (upd) begin
            table_d[bank][wr_idx] = wr_cnt_next;
        end
        mispredict_d = upd & (pc_src_pred_e_i != pc_src_res_e_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    table_q[b][i] <= SAT_CNT_RESET;
                end
            end
            mispredict_q <= 1'b0;
        end else begin
            table_q      <= table_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign mispredict_e_o = mispredict_q;

endmodule
